// File: rtl/music_ctrl.sv
// music_ctrl: turns raw game events into control inputs for the music player.
// It produces a debounced pause toggle, a row-clear jingle trigger, a latched
// game-over flag and a difficulty level. Every output comes from a register.
module music_ctrl #(
  parameter int unsigned ROWS_PER_LEVEL = 10,
  parameter int unsigned MAX_LEVEL      = 15,
  parameter int unsigned DEBOUNCE_W     = 20,
  parameter int unsigned FULL_ROW_HOLD  = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rows_vld,
  input  logic [2:0] rows_cnt,
  input  logic       pause_btn,
  input  logic       game_over,
  input  logic       new_game,
  output logic [3:0] inlevel,
  output logic       full_row,
  output logic       music_pause,
  output logic       music_game_over,
  output logic [9:0] total_rows
);

  typedef enum logic [1:0] {RUN, PAUSED, OVER} state_t;

  localparam logic [6:0] RPL   = 7'(ROWS_PER_LEVEL);
  localparam logic [3:0] LMAX  = 4'(MAX_LEVEL);
  localparam logic [7:0] HOLD  = 8'(FULL_ROW_HOLD);

  state_t                state, state_next;
  logic                  sync1, sync2;
  logic                  deb, deb_d;
  logic [DEBOUNCE_W-1:0] deb_cnt;
  logic                  press;
  logic [5:0]            acc;
  logic [7:0]            hold;
  logic                  row_ok, accept, restart;
  logic [6:0]            sum;
  logic [10:0]           total_sum;

  // Two-stage synchronizer for the asynchronous push-button
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= pause_btn;
      sync2 <= sync1;
    end
  end

  // Debounce: the new level is adopted only after it stays stable long enough
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb     <= 1'b0;
      deb_d   <= 1'b0;
      deb_cnt <= '0;
    end else begin
      deb_d <= deb;
      if (sync2 == deb) begin
        deb_cnt <= '0;
      end else if (deb_cnt == '1) begin
        deb     <= sync2;
        deb_cnt <= '0;
      end else begin
        deb_cnt <= deb_cnt + DEBOUNCE_W'(1);
      end
    end
  end

  // Press detection, row-event qualification and sums for the datapath
  always_comb begin
    press     = deb & ~deb_d;
    row_ok    = rows_vld && (rows_cnt >= 3'd1) && (rows_cnt <= 3'd4);
    sum       = {1'b0, acc} + {4'b0000, rows_cnt};
    total_sum = {1'b0, total_rows} + {8'b0, rows_cnt};
  end

  // Next state; game_over has priority over every other event
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    restart    = 1'b0;
    unique case (state)
      RUN: begin
        if (game_over) begin
          state_next = OVER;
        end else begin
          accept = row_ok;
          if (press) state_next = PAUSED;
        end
      end
      PAUSED: begin
        if (game_over)  state_next = OVER;
        else if (press) state_next = RUN;
      end
      OVER: begin
        if (!game_over && new_game) begin
          state_next = RUN;
          restart    = 1'b1;
        end
      end
      default: state_next = RUN;
    endcase
  end

  // State register and registered state-decode outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= RUN;
      music_pause     <= 1'b0;
      music_game_over <= 1'b0;
    end else begin
      state           <= state_next;
      music_pause     <= (state_next == PAUSED);
      music_game_over <= (state_next == OVER);
    end
  end

  // Row accounting, level stepping and jingle hold timer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc        <= '0;
      inlevel    <= '0;
      total_rows <= '0;
      hold       <= '0;
      full_row   <= 1'b0;
    end else if (restart) begin
      acc        <= '0;
      inlevel    <= '0;
      total_rows <= '0;
      hold       <= '0;
      full_row   <= 1'b0;
    end else begin
      if (accept) begin
        if (sum >= RPL) begin
          acc <= 6'(sum - RPL);
          if (inlevel < LMAX) inlevel <= inlevel + 4'd1;
        end else begin
          acc <= sum[5:0];
        end
        total_rows <= total_sum[10] ? '1 : total_sum[9:0];
      end
      // Leaving RUN kills the trigger so it never straddles a gated-clock pause
      if (state_next != RUN) begin
        full_row <= 1'b0;
        hold     <= '0;
      end else if (accept) begin
        full_row <= 1'b1;
        hold     <= HOLD;
      end else if (full_row) begin
        if (hold <= 8'd1) begin
          full_row <= 1'b0;
          hold     <= '0;
        end else begin
          hold <= hold - 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_music_ctrl.sv
// Testbench for music_ctrl: directed and random steps checked every cycle
// against a row-count based reference model.
module tb_music_ctrl;

  localparam int RPL  = 10;
  localparam int MAXL = 15;
  localparam int DW   = 4;
  localparam int HOLD = 16;
  // Edges from the last edge before pause_btn rises until music_pause toggles
  localparam int PRESS_LAT = 2 + (1 << DW) + 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rows_vld = 1'b0;
  logic [2:0] rows_cnt = 3'd0;
  logic       pause_btn = 1'b0;
  logic       game_over = 1'b0;
  logic       new_game = 1'b0;
  logic [3:0] inlevel;
  logic       full_row;
  logic       music_pause;
  logic       music_game_over;
  logic [9:0] total_rows;

  music_ctrl #(
    .ROWS_PER_LEVEL(RPL),
    .MAX_LEVEL(MAXL),
    .DEBOUNCE_W(DW),
    .FULL_ROW_HOLD(HOLD)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .rows_vld(rows_vld),
    .rows_cnt(rows_cnt),
    .pause_btn(pause_btn),
    .game_over(game_over),
    .new_game(new_game),
    .inlevel(inlevel),
    .full_row(full_row),
    .music_pause(music_pause),
    .music_game_over(music_game_over),
    .total_rows(total_rows)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int press_edge = -1;
  logic rst_drv = 1'b0;
  logic btn = 1'b0;

  // Reference model: accepted rows since restart, mode flags, jingle cycles left
  int m_rows   = 0;
  bit m_paused = 1'b0;
  bit m_over   = 1'b0;
  int m_full   = 0;

  int illegal_cnt[4] = '{0, 5, 6, 7};

  task automatic check(input string tag, input logic [15:0] act, input logic [15:0] exp);
    total++;
    assert (act === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, act, exp);
    end
  endtask

  task automatic check_all();
    int lvl, tot;
    lvl = m_rows / RPL;
    if (lvl > MAXL) lvl = MAXL;
    tot = (m_rows > 1023) ? 1023 : m_rows;
    check("inlevel", 16'(inlevel), 16'(lvl));
    check("total_rows", 16'(total_rows), 16'(tot));
    check("full_row", 16'(full_row), 16'(m_full > 0));
    check("music_pause", 16'(music_pause), 16'(m_paused));
    check("music_game_over", 16'(music_game_over), 16'(m_over));
  endtask

  task automatic model_clear();
    m_rows = 0; m_paused = 1'b0; m_over = 1'b0; m_full = 0;
  endtask

  task automatic step(input bit v, input int c, input bit go, input bit ng);
    bit press, accept;
    @(negedge clk);
    rows_vld  = v;
    rows_cnt  = 3'(c);
    game_over = go;
    new_game  = ng;
    pause_btn = btn;
    rst_n     = rst_drv;
    @(posedge clk);
    cyc++;
    press = (cyc == press_edge);
    if (!rst_drv) begin
      model_clear();
    end else if (m_over) begin
      if (!go && ng) model_clear();
    end else if (go) begin
      m_over = 1'b1; m_paused = 1'b0; m_full = 0;
    end else begin
      accept = !m_paused && v && (c >= 1) && (c <= 4);
      if (accept) m_rows += c;
      if (press) begin
        m_paused = !m_paused;
        m_full = 0;
      end else if (accept) begin
        m_full = HOLD;
      end else if (m_full > 0) begin
        m_full--;
      end
    end
    #1 check_all();
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 0, 1'b0, 1'b0);
  endtask

  task automatic pause_press();
    btn = 1'b1;
    press_edge = cyc + PRESS_LAT;
    idle(30);
    btn = 1'b0;
    idle(25);
  endtask

  initial begin
    // Reset held across clock edges
    idle(2);
    rst_drv = 1'b1;
    idle(3);

    // Level accumulation 4,4,4 and jingle hold
    step(1'b1, 4, 1'b0, 1'b0);
    step(1'b1, 4, 1'b0, 1'b0);
    step(1'b1, 4, 1'b0, 1'b0);
    idle(20);

    // Short glitch on the button
    btn = 1'b1; idle(10);
    btn = 1'b0; idle(30);

    // Real press, rows while paused, second press
    step(1'b1, 3, 1'b0, 1'b0);
    pause_press();
    repeat (5) step(1'b1, int'($urandom_range(1, 4)), 1'b0, 1'b0);
    pause_press();

    // Press and row event in the same cycle
    step(1'b1, 4, 1'b0, 1'b0);
    btn = 1'b1;
    press_edge = cyc + PRESS_LAT;
    for (int i = 0; i < 30; i++) step(cyc + 1 == press_edge, 3, 1'b0, 1'b0);
    btn = 1'b0;
    idle(25);
    pause_press();

    // Illegal row counts
    foreach (illegal_cnt[i]) step(1'b1, illegal_cnt[i], 1'b0, 1'b0);
    idle(2);

    // Random row traffic
    repeat (200) step(1'($urandom_range(0, 1)), int'($urandom_range(0, 7)), 1'b0, 1'b0);

    // Saturation of level and total
    repeat (300) step(1'b1, 4, 1'b0, 1'b0);
    idle(3);

    // Game over during a hold, colliding with a row event
    step(1'b1, 2, 1'b0, 1'b0);
    idle(3);
    step(1'b1, 1, 1'b1, 1'b0);
    idle(3);
    btn = 1'b1;
    press_edge = cyc + PRESS_LAT;
    repeat (30) step(1'b0, 0, 1'b1, 1'b0);
    btn = 1'b0;
    repeat (25) step(1'b0, 0, 1'b1, 1'b0);
    step(1'b0, 0, 1'b1, 1'b1);
    step(1'b0, 0, 1'b0, 1'b0);
    step(1'b0, 0, 1'b0, 1'b1);
    idle(3);

    // Asynchronous reset mid-hold and mid-debounce
    step(1'b1, 4, 1'b0, 1'b0);
    btn = 1'b1;
    idle(5);
    #1;
    rst_drv = 1'b0;
    rst_n = 1'b0;
    press_edge = -1;
    model_clear();
    #1 check_all();
    idle(2);
    rst_drv = 1'b1;
    press_edge = cyc + PRESS_LAT;
    idle(25);
    btn = 1'b0;
    idle(25);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
